// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-controller signals of the two-port memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic ack0, ack1, err, busy;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic mem_we, mem_go, mem_done;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_done,
    output ack0, ack1, err, busy, rdata0, rdata1, mem_addr, mem_wdata, mem_we, mem_go
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_done,
    input  ack0, ack1, err, busy, rdata0, rdata1, mem_addr, mem_wdata, mem_we, mem_go
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory controller between two requesters
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  state_t state, state_n;
  logic last, last_n, we_q, we_n, go_q, go_n, ack0_q, ack0_n, ack1_q, ack1_n;
  logic err_q, err_n, busy_q, busy_n;
  logic [15:0] timer, timer_n, tick;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n, rd0_q, rd0_n, rd1_q, rd1_n, rd_cap;
  logic win, waiting, done_ok, tmo, fin;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_go    = go_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.rdata0    = rd0_q;
  assign bus.rdata1    = rd1_q;
  // next state and next registered outputs; last doubles as the current winner after grant
  always_comb begin
    win     = (bus.req0 & bus.req1) ? ~last : bus.req1;
    tick    = timer + 16'd1;
    waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
    done_ok = (state == WAIT_DONE) && bus.mem_done;
    tmo     = waiting && (tick >= TMO) && !done_ok;
    fin     = done_ok || tmo;
    rd_cap  = tmo ? '0 : bus.mem_rdata;
    state_n = state;
    last_n  = last;
    timer_n = waiting ? tick : timer;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    we_n    = we_q;
    go_n    = 1'b0;
    ack0_n  = fin & ~last;
    ack1_n  = fin & last;
    err_n   = fin ? tmo : err_q;
    rd0_n   = (fin && !we_q && !last) ? rd_cap : rd0_q;
    rd1_n   = (fin && !we_q && last) ? rd_cap : rd1_q;
    case (state)
      IDLE: if ((bus.req0 | bus.req1) & bus.mem_done) begin
        state_n = WAIT_BUSY;
        last_n  = win;
        addr_n  = win ? bus.addr1 : bus.addr0;
        wdata_n = win ? bus.wdata1 : bus.wdata0;
        we_n    = win ? bus.we1 : bus.we0;
        go_n    = 1'b1;
        timer_n = '0;
        err_n   = 1'b0;
      end
      WAIT_BUSY: state_n = tmo ? RESP : (bus.mem_done ? WAIT_BUSY : WAIT_DONE);
      WAIT_DONE: state_n = fin ? RESP : WAIT_DONE;
      RESP:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  // state and output registers; reset abandons any transaction and favours port 0 next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      timer   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      go_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      timer   <= timer_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      we_q    <= we_n;
      go_q    <= go_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      rd0_q   <= rd0_n;
      rd1_q   <= rd1_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the two-port memory arbiter against a simple controller model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
  int checks = 0, errors = 0;
  int cyc = 0, go_cyc = 0, go_cnt = 0, ack_cnt = 0, both_cnt = 0;
  int mode = 0, ph = 0;
  int p, g0, a0;
  logic [DW-1:0] rd_val = '0;
  logic [AW-1:0] go_addr = '0;
  logic go_we = 1'b0;
  // mode 0: answers a go by dropping done for one cycle then raising it with rd_val; 1: done stuck high; 2: done stuck low
  always @(negedge clk)
    if (mode == 1) begin
      mif.mem_done <= 1'b1;
      ph <= 0;
    end else if (mode == 2) begin
      mif.mem_done <= 1'b0;
      ph <= 0;
    end else if (mif.mem_go) ph <= 1;
    else if (ph == 1) begin
      mif.mem_done <= 1'b0;
      ph <= 0;
    end else begin
      mif.mem_done  <= 1'b1;
      mif.mem_rdata <= rd_val;
    end
  always @(posedge clk) cyc <= cyc + 1;
  // records each command strobe and ack pulse
  always @(negedge clk) begin
    if (mif.mem_go) begin
      go_cnt  <= go_cnt + 1;
      go_cyc  <= cyc;
      go_addr <= mif.mem_addr;
      go_we   <= mif.mem_we;
    end
    if (mif.ack0 | mif.ack1) ack_cnt <= ack_cnt + 1;
    if (mif.ack0 & mif.ack1) both_cnt <= both_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_ack(output int port);
    port = -1;
    for (int i = 0; i < 100 && port < 0; i++) begin
      @(negedge clk);
      if (mif.ack0) port = 0;
      else if (mif.ack1) port = 1;
    end
    if (port < 0) chk("ack_wait", 0, 1);
  endtask
  initial begin
    mif.mem_rdata = '0;
    {mif.req0, mif.req1, mif.we0, mif.we1} = '0;
    {mif.addr0, mif.addr1, mif.wdata0, mif.wdata1} = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {mif.busy, mif.mem_go, mif.mem_we, mif.ack0, mif.ack1, mif.err}, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_rdata", {mif.rdata1, mif.rdata0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_val = 8'hA3;
    g0 = go_cnt;
    mif.req0 = 1'b1;
    mif.addr0 = 32'h5;
    wait_ack(p);
    mif.req0 = 1'b0;
    chk("rd_port", p, 0);
    chk("rd_addr", go_addr, 32'h5);
    chk("rd_we", go_we, 0);
    chk("rd_data", mif.rdata0, 8'hA3);
    chk("rd_err", mif.err, 0);
    chk("rd_lat", cyc - go_cyc, 3);
    chk("rd_go_once", go_cnt - g0, 1);
    @(negedge clk);
    chk("rd_ack_pulse", mif.ack0, 0);
    chk("rd_hold", mif.rdata0, 8'hA3);
    rd_val = 8'h5C;
    mif.req1 = 1'b1;
    mif.addr1 = 32'h10;
    wait_ack(p);
    mif.req1 = 1'b0;
    chk("rd1_port", p, 1);
    chk("rd1_data", mif.rdata1, 8'h5C);
    chk("rd1_iso", mif.rdata0, 8'hA3);
    @(negedge clk);
    rd_val = 8'h77;
    g0 = go_cnt;
    mif.req1 = 1'b1;
    mif.we1 = 1'b1;
    mif.addr1 = 32'h3;
    mif.wdata1 = 8'h9;
    @(negedge clk);
    chk("wr_go", mif.mem_go, 1);
    mif.addr1 = 32'hFF;
    mif.wdata1 = 8'hEE;
    mif.we1 = 1'b0;
    wait_ack(p);
    mif.req1 = 1'b0;
    chk("wr_port", p, 1);
    chk("wr_cmd", {mif.mem_we, mif.mem_wdata, mif.mem_addr[7:0]}, {1'b1, 8'h9, 8'h3});
    chk("wr_rdata", mif.rdata1, 8'h5C);
    chk("wr_go_once", go_cnt - g0, 1);
    rd_val = 8'h3C;
    rst_n = 1'b0;
    mif.req0 = 1'b1;
    mif.addr0 = 32'h100;
    mif.req1 = 1'b1;
    mif.addr1 = 32'h200;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(p);
      chk("rr_port", p, k % 2);
      chk("rr_addr", go_addr, (k % 2) ? 32'h200 : 32'h100);
    end
    mif.req0 = 1'b0;
    mif.req1 = 1'b0;
    @(posedge clk);
    #1 mode = 1;
    @(negedge clk);
    mif.req0 = 1'b1;
    mif.addr0 = 32'h7;
    wait_ack(p);
    mif.req0 = 1'b0;
    chk("to_port", p, 0);
    chk("to_err", mif.err, 1);
    chk("to_rdata", mif.rdata0, 0);
    chk("to_lat", cyc - go_cyc, 8);
    @(posedge clk);
    #1 mode = 2;
    @(negedge clk);
    g0 = go_cnt;
    mif.req0 = 1'b1;
    mif.addr0 = 32'h8;
    repeat (4) @(negedge clk);
    chk("busy_nogo", go_cnt - g0, 0);
    chk("busy_err_held", mif.err, 1);
    chk("busy_idle", mif.busy, 0);
    @(posedge clk);
    #1 mode = 0;
    rd_val = 8'h66;
    @(negedge clk);
    #1;
    chk("busy_done_up", mif.mem_done, 1);
    chk("busy_go_wait", mif.mem_go, 0);
    @(negedge clk);
    chk("busy_go_next", mif.mem_go, 1);
    chk("err_clear", mif.err, 0);
    wait_ack(p);
    mif.req0 = 1'b0;
    chk("busy_rd", {p[7:0], mif.rdata0, 7'd0, mif.err}, {8'd0, 8'h66, 8'd0});
    @(negedge clk);
    rd_val = 8'h11;
    mif.req0 = 1'b1;
    mif.addr0 = 32'h9;
    @(negedge clk);
    chk("mid_go", mif.mem_go, 1);
    mif.req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", mif.busy, 1);
    a0 = ack_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {mif.busy, mif.mem_go, mif.mem_we, mif.ack0, mif.ack1, mif.err}, 0);
    chk("mid_rst_addr", mif.mem_addr, 0);
    chk("mid_rst_rdata", {mif.rdata1, mif.rdata0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_no_ack", ack_cnt - a0, 0);
    rd_val = 8'h42;
    mif.req0 = 1'b1;
    mif.addr0 = 32'hA;
    wait_ack(p);
    mif.req0 = 1'b0;
    chk("post_port", p, 0);
    chk("post_rdata", mif.rdata0, 8'h42);
    chk("post_err", mif.err, 0);
    chk("post_addr", go_addr, 32'hA);
    @(negedge clk);
    chk("ack_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
